// File: rtl/csr_excp_ctrl.sv
// csr_excp_ctrl: prioritises WB exceptions/interrupts/ertn, strobes the CSR commit,
// then sequences flush, pre-IF redirect handshake and pipeline drain.
module csr_excp_ctrl #(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc_in,
    input  logic [31:0] wb_vaddr_in,
    input  logic [4:0]  wb_exc_vec,
    input  logic        wb_ertn,
    input  logic        has_int,
    input  logic [31:0] ex_entry,
    input  logic [31:0] ertn_entry,
    output logic        wb_allowin,
    output logic        wb_kill,
    output logic        wb_ex,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic        ertn_flush,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_vaddr,
    output logic        flush_all,
    output logic        redir_valid,
    output logic [31:0] redir_target,
    input  logic        redir_ready
);
    typedef enum logic [1:0] {IDLE, COMMIT, REDIRECT, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [5:0]  ecode_q, ecode_d;
    logic        ertn_q, ertn_d;
    logic [31:0] pc_q, pc_d, vaddr_q, vaddr_d, target_q, target_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        exc, evt, idle, commit, redirect;

    assign exc      = has_int | (|wb_exc_vec);
    assign evt      = wb_valid & (exc | wb_ertn);
    assign idle     = state_q == IDLE;
    assign commit   = state_q == COMMIT;
    assign redirect = state_q == REDIRECT;

    always_comb begin
        state_d  = state_q;
        ecode_d  = ecode_q;
        ertn_d   = ertn_q;
        pc_d     = pc_q;
        vaddr_d  = vaddr_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: if (evt) begin
                state_d = COMMIT;
                ertn_d  = ~exc;
                pc_d    = wb_pc_in;
                ecode_d = has_int       ? 6'h00 :
                          wb_exc_vec[0] ? 6'h08 :
                          wb_exc_vec[1] ? 6'h0D :
                          wb_exc_vec[2] ? 6'h0B :
                          wb_exc_vec[3] ? 6'h0C :
                          wb_exc_vec[4] ? 6'h09 : 6'h00;
                // BADV only reported when ADEF or ALE is the winning cause
                vaddr_d = has_int       ? 32'd0    :
                          wb_exc_vec[0] ? wb_pc_in :
                          (wb_exc_vec[4] & ~|wb_exc_vec[3:1]) ? wb_vaddr_in : 32'd0;
            end
            COMMIT: begin
                state_d  = REDIRECT;
                target_d = ertn_q ? ertn_entry : ex_entry;
            end
            REDIRECT: if (redir_ready) begin
                state_d = DRAIN;
                cnt_d   = 4'(DRAIN_CYCLES - 1);
            end
            default: begin
                state_d = (cnt_q == 4'd0) ? IDLE : DRAIN;
                cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            ecode_q  <= '0;
            ertn_q   <= 1'b0;
            pc_q     <= '0;
            vaddr_q  <= '0;
            target_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ecode_q  <= ecode_d;
            ertn_q   <= ertn_d;
            pc_q     <= pc_d;
            vaddr_q  <= vaddr_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
        end
    end

    // resetn gating keeps IDLE-derived outputs at 0 while reset is held
    assign wb_allowin   = idle & resetn;
    assign wb_kill      = idle & resetn & evt;
    assign wb_ex        = commit & ~ertn_q;
    assign ertn_flush   = commit & ertn_q;
    assign wb_ecode     = commit ? ecode_q : 6'd0;
    assign wb_esubcode  = 9'd0;
    assign wb_pc        = commit ? pc_q : 32'd0;
    assign wb_vaddr     = commit ? vaddr_q : 32'd0;
    assign flush_all    = commit | redirect;
    assign redir_valid  = redirect;
    assign redir_target = redirect ? target_q : 32'd0;
endmodule

// File: tb/tb_csr_excp_ctrl.sv
// tb_csr_excp_ctrl: scenario tasks drive WB events; a commit monitor pops expected
// commits from a scoreboard queue and checks strobes and redirect target.
module tb_csr_excp_ctrl;
    logic        clk = 1'b0, resetn = 1'b0;
    logic        wb_valid = 1'b0, wb_ertn = 1'b0, has_int = 1'b0, redir_ready = 1'b1;
    logic [31:0] wb_pc_in = '0, wb_vaddr_in = '0;
    logic [31:0] ex_entry = 32'h1C008000, ertn_entry = 32'h1C000200;
    logic [4:0]  wb_exc_vec = '0;
    logic        wb_allowin, wb_kill, wb_ex, ertn_flush, flush_all, redir_valid;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc, wb_vaddr, redir_target;

    typedef struct {
        logic        ex;
        logic [5:0]  ecode;
        logic [31:0] pc;
        logic [31:0] vaddr;
        logic [31:0] tgt;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic [31:0] tgt_exp = '0;
    int          checks = 0, fails = 0;

    csr_excp_ctrl #(.DRAIN_CYCLES(2)) dut (
        .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc_in(wb_pc_in),
        .wb_vaddr_in(wb_vaddr_in), .wb_exc_vec(wb_exc_vec), .wb_ertn(wb_ertn),
        .has_int(has_int), .ex_entry(ex_entry), .ertn_entry(ertn_entry),
        .wb_allowin(wb_allowin), .wb_kill(wb_kill), .wb_ex(wb_ex), .wb_ecode(wb_ecode),
        .wb_esubcode(wb_esubcode), .ertn_flush(ertn_flush), .wb_pc(wb_pc),
        .wb_vaddr(wb_vaddr), .flush_all(flush_all), .redir_valid(redir_valid),
        .redir_target(redir_target), .redir_ready(redir_ready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (resetn) begin
        if (wb_ex | ertn_flush) begin
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_commit: wb_ex=%b ertn_flush=%b, required no commit", wb_ex, ertn_flush);
            end else begin
                cur = sb.pop_front();
                tgt_exp = cur.tgt;
                if (wb_ex !== cur.ex || ertn_flush !== !cur.ex || wb_esubcode !== 9'd0 ||
                    (cur.ex && {wb_ecode, wb_pc, wb_vaddr} !== {cur.ecode, cur.pc, cur.vaddr})) begin
                    fails++;
                    $display("FAIL commit: ex=%b ertn=%b ecode=%h sub=%h pc=%h va=%h, required ex=%b ertn=%b ecode=%h sub=0 pc=%h va=%h",
                             wb_ex, ertn_flush, wb_ecode, wb_esubcode, wb_pc, wb_vaddr,
                             cur.ex, !cur.ex, cur.ecode, cur.pc, cur.vaddr);
                end
            end
        end else begin
            checks++;
            if ({wb_ecode, wb_esubcode, wb_pc, wb_vaddr} !== '0) begin
                fails++;
                $display("FAIL idle_fields: ecode=%h sub=%h pc=%h va=%h, required all 0", wb_ecode, wb_esubcode, wb_pc, wb_vaddr);
            end
        end
        if (redir_valid) begin
            checks++;
            if (redir_target !== tgt_exp || flush_all !== 1'b1) begin
                fails++;
                $display("FAIL redir_target: got %h flush=%b, required %h flush=1", redir_target, flush_all, tgt_exp);
            end
        end
    end

    task automatic set_wb(input logic v, input logic [31:0] pc, va, input logic [4:0] vec, input logic er, it);
        wb_valid = v; wb_pc_in = pc; wb_vaddr_in = va; wb_exc_vec = vec; wb_ertn = er; has_int = it;
    endtask

    task automatic fire(input logic [31:0] pc, va, input logic [4:0] vec, input logic er, it);
        @(posedge clk); #1;
        set_wb(1'b1, pc, va, vec, er, it);
        #1;
    endtask

    task automatic clear_next;
        @(posedge clk); #1;
        set_wb(1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 40 && wb_allowin !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (wb_allowin !== 1'b1) begin
            fails++;
            $display("FAIL %s_return_idle: wb_allowin=%b, required 1 within 40 cycles", name, wb_allowin);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({wb_allowin, wb_kill, wb_ex, ertn_flush, flush_all, redir_valid, redir_target} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: allowin=%b kill=%b ex=%b ertn=%b flush=%b rv=%b tgt=%h, required all 0",
                     wb_allowin, wb_kill, wb_ex, ertn_flush, flush_all, redir_valid, redir_target);
        end
        resetn = 1'b1;
        #1;
        checks++;
        if (wb_allowin !== 1'b1 || flush_all !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: allowin=%b flush=%b, required 1 0", wb_allowin, flush_all);
        end
    endtask

    task automatic test_sys;
        fire(32'h1C0000F0, '0, 5'b00000, 1'b0, 1'b0);
        checks++;
        if (wb_kill !== 1'b0 || wb_allowin !== 1'b1) begin
            fails++;
            $display("FAIL normal_retire: kill=%b allowin=%b, required 0 1", wb_kill, wb_allowin);
        end
        sb.push_back('{1'b1, 6'h0B, 32'h1C000100, 32'h0, 32'h1C008000});
        fire(32'h1C000100, '0, 5'b00100, 1'b0, 1'b0);
        checks++;
        if (wb_kill !== 1'b1) begin
            fails++;
            $display("FAIL sys_kill: wb_kill=%b, required 1", wb_kill);
        end
        clear_next();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wb_allowin !== 1'b0 || wb_kill !== 1'b0 || flush_all !== (i < 2)) begin
                fails++;
                $display("FAIL sys_latency cycle %0d: allowin=%b kill=%b flush=%b, required 0 0 %b",
                         i, wb_allowin, wb_kill, flush_all, i < 2);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (wb_allowin !== 1'b1) begin
            fails++;
            $display("FAIL sys_allowin_return: wb_allowin=%b, required 1 after 4 cycles", wb_allowin);
        end
    endtask

    task automatic test_ale_int;
        sb.push_back('{1'b1, 6'h00, 32'h1C000300, 32'h0, 32'h1C008000});
        fire(32'h1C000300, 32'h00000003, 5'b10000, 1'b0, 1'b1);
        checks++;
        if (wb_kill !== 1'b1) begin
            fails++;
            $display("FAIL int_kill: wb_kill=%b, required 1", wb_kill);
        end
        clear_next();
        wait_idle("ale_int");
        sb.push_back('{1'b1, 6'h09, 32'h1C000304, 32'h00000003, 32'h1C008000});
        fire(32'h1C000304, 32'h00000003, 5'b10000, 1'b0, 1'b0);
        clear_next();
        wait_idle("ale");
    endtask

    task automatic test_multi_exc;
        sb.push_back('{1'b1, 6'h08, 32'h1C000401, 32'h1C000401, 32'h1C008000});
        fire(32'h1C000401, 32'h00000055, 5'b01011, 1'b0, 1'b0);
        clear_next();
        wait_idle("adef_ine_brk");
        sb.push_back('{1'b1, 6'h0C, 32'h1C000408, 32'h0, 32'h1C008000});
        fire(32'h1C000408, 32'h00000055, 5'b11000, 1'b0, 1'b0);
        clear_next();
        wait_idle("brk_ale");
    endtask

    task automatic test_ertn;
        sb.push_back('{1'b0, 6'h00, 32'h1C000500, 32'h0, 32'h1C000200});
        fire(32'h1C000500, '0, 5'b00000, 1'b1, 1'b0);
        checks++;
        if (wb_kill !== 1'b1) begin
            fails++;
            $display("FAIL ertn_kill: wb_kill=%b, required 1", wb_kill);
        end
        clear_next();
        wait_idle("ertn");
        sb.push_back('{1'b1, 6'h0D, 32'h1C000504, 32'h0, 32'h1C008000});
        fire(32'h1C000504, '0, 5'b00010, 1'b1, 1'b0);
        clear_next();
        wait_idle("ertn_ine");
    endtask

    task automatic test_redirect_stall;
        redir_ready = 1'b0;
        sb.push_back('{1'b1, 6'h0C, 32'h1C000600, 32'h0, 32'h1C008000});
        fire(32'h1C000600, '0, 5'b01000, 1'b0, 1'b0);
        @(posedge clk); #1;
        set_wb(1'b1, 32'h1C000700, 32'h0, 5'b00001, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (wb_allowin !== 1'b0 || wb_kill !== 1'b0 || (i > 0 && redir_valid !== 1'b1)) begin
                fails++;
                $display("FAIL stall cycle %0d: allowin=%b kill=%b rv=%b, required 0 0 %b",
                         i, wb_allowin, wb_kill, redir_valid, i > 0);
            end
            @(posedge clk); #1;
        end
        set_wb(1'b0, '0, '0, '0, 1'b0, 1'b0);
        redir_ready = 1'b1;
        wait_idle("stall");
    endtask

    task automatic test_reset_in_redirect;
        redir_ready = 1'b0;
        sb.push_back('{1'b1, 6'h0B, 32'h1C000800, 32'h0, 32'h1C008000});
        fire(32'h1C000800, '0, 5'b00100, 1'b0, 1'b0);
        clear_next();
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        checks++;
        if ({wb_allowin, wb_kill, wb_ex, ertn_flush, flush_all, redir_valid, redir_target, wb_pc} !== '0) begin
            fails++;
            $display("FAIL reset_mid_redirect: allowin=%b ex=%b flush=%b rv=%b tgt=%h, required all 0",
                     wb_allowin, wb_ex, flush_all, redir_valid, redir_target);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        redir_ready = 1'b1;
        sb.push_back('{1'b1, 6'h09, 32'h1C000900, 32'h00000006, 32'h1C008000});
        fire(32'h1C000900, 32'h00000006, 5'b10000, 1'b0, 1'b0);
        checks++;
        if (wb_kill !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_kill: wb_kill=%b, required 1", wb_kill);
        end
        clear_next();
        wait_idle("post_reset");
    endtask

    initial begin
        test_reset();
        test_sys();
        test_ale_int();
        test_multi_exc();
        test_ertn();
        test_redirect_stall();
        test_reset_in_redirect();
        repeat (2) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d commits outstanding, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
